// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, framing constants and field widths
// for program_loader and its word_packer helper.
package loader_pkg;

    // Frame-parsing states; CHECK is only reachable when the checksum
    // option (PROGRAM_LOADER_CHECKSUM_EN) is compiled in.
    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;
    localparam int IDX_W  = 2;

    // True for every state in which the loader still wants stream bytes.
    function automatic logic stateAcceptsBytes(input loader_state_e s);
        return (s != ST_DONE) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: collects stream bytes into 32-bit little-endian words.
// Holds the 2-bit byte index and a 24-bit partial-word shifter; the
// fourth byte of a word is combined directly with the shifter so the
// complete word is available in the same cycle it is accepted.
// With PROGRAM_LOADER_CHECKSUM_EN defined it also keeps the running XOR
// of every byte the top level marks for inclusion.
module word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              clear_i,
    input  logic              shiftEn_i,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    input  logic              xorEn_i,
    output logic [BYTE_W-1:0] xorSum_o,
`endif
    input  logic [BYTE_W-1:0] dataByte_i,
    output logic              wordComplete_o,
    output logic [WORD_W-1:0] word_o
);

    logic [IDX_W-1:0]         byteIdx_q, byteIdx_d;
    logic [WORD_W-BYTE_W-1:0] shift_q,   shift_d;

    // Advance the byte index and shift new bytes in from the top (LSB first on the wire).
    always_comb begin
        byteIdx_d = byteIdx_q;
        shift_d   = shift_q;
        if (clear_i) begin
            byteIdx_d = '0;
            shift_d   = '0;
        end else if (shiftEn_i) begin
            byteIdx_d = byteIdx_q + IDX_W'(1);
            shift_d   = {dataByte_i, shift_q[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    // Byte index and partial-word registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            byteIdx_q <= '0;
            shift_q   <= '0;
        end else begin
            byteIdx_q <= byteIdx_d;
            shift_q   <= shift_d;
        end
    end

    assign wordComplete_o = shiftEn_i && (byteIdx_q == '1);
    assign word_o         = {dataByte_i, shift_q};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q, xor_d;

    // Running XOR over length and data bytes, restarted while hunting for sync.
    always_comb begin
        xor_d = xor_q;
        if (clear_i) begin
            xor_d = '0;
        end else if (xorEn_i) begin
            xor_d = xor_q ^ dataByte_i;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end

    assign xorSum_o = xor_q;
`endif

endmodule

// File: rtl/program_loader.sv
// program_loader: boot-time instruction-memory writer.
// Parses a framed byte stream (A5, LEN_LO, LEN_HI, LEN*4 data bytes, LSB
// first) arriving over valid/ready, writes each completed word into the
// instruction memory, and holds the CPU in reset until the frame is in.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the CPU is released.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic [7:0]    inData,
    input  logic          inValid,
    output logic          inReady,
    input  logic          reload,
    output logic          imemWe,
    output logic [AW-1:0] imemAddr,
    output logic [31:0]   imemData,
    output logic          cpuReset,
    output logic          done,
    output logic          error,
    output logic [AW:0]   wordCount
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_e ST_AFTER_DATA = ST_CHECK;
`else
    localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    loader_state_e     state_q, state_d;
    logic [BYTE_W-1:0] lenLo_q, lenLo_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [AW:0]       wordCount_q, wordCount_d;
    logic              inReady_q, inReady_d;
    logic              imemWe_q, imemWe_d;
    logic [AW-1:0]     imemAddr_q, imemAddr_d;
    logic [WORD_W-1:0] imemData_q, imemData_d;
    logic              cpuReset_q, cpuReset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [LEN_W-1:0]  lenFull;
    logic              packClear;
    logic              packShift;
    logic              wordComplete;
    logic [WORD_W-1:0] packedWord;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic              packXor;
    logic [BYTE_W-1:0] xorSum;
`endif

    // A byte moves only when we advertised ready on the previous edge.
    assign accept  = inValid && inReady_q;
    assign lenFull = {inData, lenLo_q};

    word_packer u_packer (
        .clk            (clk),
        .resetN         (resetN),
        .clear_i        (packClear),
        .shiftEn_i      (packShift),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .xorEn_i        (packXor),
        .xorSum_o       (xorSum),
`endif
        .dataByte_i     (inData),
        .wordComplete_o (wordComplete),
        .word_o         (packedWord)
    );

    // Frame-parsing FSM next state together with the registered-output values it implies.
    always_comb begin
        state_d     = state_q;
        lenLo_d     = lenLo_q;
        len_d       = len_q;
        wordCount_d = wordCount_q;
        imemWe_d    = 1'b0;
        imemAddr_d  = imemAddr_q;
        imemData_d  = imemData_q;
        packClear   = 1'b0;
        packShift   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        packXor     = 1'b0;
`endif

        case (state_q)
            ST_SYNC: begin
                packClear = 1'b1;
                if (accept && (inData == LOADER_SYNC_BYTE)) begin
                    state_d = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    packXor = 1'b1;
`endif
                    lenLo_d = inData;
                    state_d = ST_LEN_HI;
                end
            end

            ST_LEN_HI: begin
                if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    packXor = 1'b1;
`endif
                    len_d = lenFull;
                    if (lenFull > DEPTH_LEN) begin
                        state_d = ST_ERROR;
                    end else if (lenFull == '0) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    packShift = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    packXor   = 1'b1;
`endif
                    if (wordComplete) begin
                        imemWe_d    = 1'b1;
                        imemAddr_d  = wordCount_q[AW-1:0];
                        imemData_d  = packedWord;
                        wordCount_d = wordCount_q + (AW+1)'(1);
                        if (LEN_W'(wordCount_d) == len_q) begin
                            state_d = ST_AFTER_DATA;
                        end
                    end
                end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    state_d = (inData == xorSum) ? ST_DONE : ST_ERROR;
                end
            end
`endif

            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d     = ST_SYNC;
                    wordCount_d = '0;
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase

        inReady_d  = stateAcceptsBytes(state_d);
        cpuReset_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
    end

    // State, counters and registered outputs; reset idles the port and holds the CPU in reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_SYNC;
            lenLo_q     <= '0;
            len_q       <= '0;
            wordCount_q <= '0;
            inReady_q   <= 1'b0;
            imemWe_q    <= 1'b0;
            imemAddr_q  <= '0;
            imemData_q  <= '0;
            cpuReset_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lenLo_q     <= lenLo_d;
            len_q       <= len_d;
            wordCount_q <= wordCount_d;
            inReady_q   <= inReady_d;
            imemWe_q    <= imemWe_d;
            imemAddr_q  <= imemAddr_d;
            imemData_q  <= imemData_d;
            cpuReset_q  <= cpuReset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign inReady   = inReady_q;
    assign imemWe    = imemWe_q;
    assign imemAddr  = imemAddr_q;
    assign imemData  = imemData_q;
    assign cpuReset  = cpuReset_q;
    assign done      = done_q;
    assign error     = error_q;
    assign wordCount = wordCount_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized, self-checking bench for program_loader.
// A byte-position frame interpreter predicts every output each cycle; a
// negedge process compares the DUT against it, and literal expectations
// from hand-worked frames pin the interpreter.
// Honours PROGRAM_LOADER_CHECKSUM_EN the same way the design does.
module tb_program_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int M_LOADING = 0;
    localparam int M_DONE    = 1;
    localparam int M_ERROR   = 2;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic [7:0]    inData = 8'h00;
    logic          inValid = 1'b0;
    logic          reload = 1'b0;
    logic          inReady;
    logic          imemWe;
    logic [AW-1:0] imemAddr;
    logic [31:0]   imemData;
    logic          cpuReset;
    logic          done;
    logic          error;
    logic [AW:0]   wordCount;

    int testsRun = 0;
    int testsFailed = 0;

    // Stimulus staging and captured DUT writes.
    logic [7:0]  txGarbage[$];
    logic [7:0]  txData[$];
    logic [31:0] capData[$];
    int          capAddr[$];
    int          weCycles = 0;

    // Reference interpreter state.
    bit          mReady = 1'b0;
    bit          mWe = 1'b0;
    int          mAddr = 0;
    logic [31:0] mData = 32'h0;
    bit          mCpu = 1'b1;
    bit          mDone = 1'b0;
    bit          mErr = 1'b0;
    int          mCount = 0;
    int          mStatus = M_LOADING;
    int          mPos = -1;
    int          mLen = 0;
    int          mK = 0;
    logic [7:0]  mCsum = 8'h00;
    logic [7:0]  mByte = 8'h00;
    logic [31:0] mAcc = 32'h0;

    program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .inData    (inData),
        .inValid   (inValid),
        .inReady   (inReady),
        .reload    (reload),
        .imemWe    (imemWe),
        .imemAddr  (imemAddr),
        .imemData  (imemData),
        .cpuReset  (cpuReset),
        .done      (done),
        .error     (error),
        .wordCount (wordCount)
    );

    always #5 clk = ~clk;

    // Frame interpreter: tracks position since the sync byte and derives outputs from it.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mReady = 1'b0; mWe = 1'b0; mAddr = 0; mData = 32'h0;
            mCpu = 1'b1; mDone = 1'b0; mErr = 1'b0; mCount = 0;
            mStatus = M_LOADING; mPos = -1; mLen = 0; mCsum = 8'h00; mAcc = 32'h0;
        end else begin
            mWe = 1'b0;
            if (mStatus != M_LOADING) begin
                if (reload) begin
                    mStatus = M_LOADING;
                    mPos = -1;
                    mCount = 0;
                end
            end else if (inValid && mReady) begin
                mByte = inData;
                if (mPos < 0) begin
                    if (mByte == 8'hA5) begin
                        mPos = 0;
                        mCsum = 8'h00;
                    end
                end else if (mPos == 0) begin
                    mLen = int'(mByte);
                    mCsum ^= mByte;
                    mPos = 1;
                end else if (mPos == 1) begin
                    mLen = mLen + int'(mByte) * 256;
                    mCsum ^= mByte;
                    mPos = 2;
                    if (mLen > DEPTH) mStatus = M_ERROR;
                    else if (mLen == 0 && !CK_EN) mStatus = M_DONE;
                end else if (mPos < 2 + 4 * mLen) begin
                    mK = mPos - 2;
                    mCsum ^= mByte;
                    mAcc[8 * (mK % 4) +: 8] = mByte;
                    if (mK % 4 == 3) begin
                        mWe = 1'b1;
                        mAddr = mK / 4;
                        mData = mAcc;
                        mCount = mK / 4 + 1;
                        if (mCount == mLen && !CK_EN) mStatus = M_DONE;
                    end
                    mPos++;
                end else begin
                    mStatus = (mByte == mCsum) ? M_DONE : M_ERROR;
                end
            end
            mReady = (mStatus == M_LOADING);
            mDone  = (mStatus == M_DONE);
            mErr   = (mStatus == M_ERROR);
            mCpu   = !mDone;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name, input int cycles);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out after %0d cycles, required handshake", name, cycles);
    endtask

    // Per-cycle comparison against the interpreter, plus capture of DUT writes.
    always @(negedge clk) begin
        checkOutput("inReady",   32'(inReady),   32'(mReady));
        checkOutput("imemWe",    32'(imemWe),    32'(mWe));
        checkOutput("imemAddr",  32'(imemAddr),  32'(mAddr));
        checkOutput("imemData",  imemData,       mData);
        checkOutput("cpuReset",  32'(cpuReset),  32'(mCpu));
        checkOutput("done",      32'(done),      32'(mDone));
        checkOutput("error",     32'(error),     32'(mErr));
        checkOutput("wordCount", 32'(wordCount), 32'(mCount));
        if (imemWe === 1'b1) begin
            capAddr.push_back(int'(imemAddr));
            capData.push_back(imemData);
            weCycles++;
        end
    end

    // Offer one byte, optionally after an idle cycle, until the DUT takes it.
    task automatic applyStimulus(input logic [7:0] b, input int gapMode);
        int  waited;
        bit  accepted;
        waited = 0;
        accepted = 1'b0;
        if (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 99) < 30)) begin
            inValid = 1'b0;
            @(posedge clk); #1;
        end
        inData = b;
        inValid = 1'b1;
        while (!accepted && waited < 40) begin
            accepted = inReady;
            @(posedge clk); #1;
            waited++;
        end
        inValid = 1'b0;
        if (!accepted) timeoutFail("byte handshake", waited);
    endtask

    task automatic pushWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) txData.push_back(w[8 * i +: 8]);
    endtask

    task automatic sendFrame(input int len, input int gapMode, input bit goodCk);
        logic [7:0]  ck;
        logic [15:0] len16;
        len16 = 16'(len);
        capAddr.delete();
        capData.delete();
        weCycles = 0;
        foreach (txGarbage[i]) applyStimulus(txGarbage[i], gapMode);
        applyStimulus(8'hA5, gapMode);
        applyStimulus(len16[7:0], gapMode);
        applyStimulus(len16[15:8], gapMode);
        ck = len16[7:0] ^ len16[15:8];
        if (len <= DEPTH) begin
            foreach (txData[i]) begin
                applyStimulus(txData[i], gapMode);
                ck ^= txData[i];
            end
            if (!goodCk) ck ^= 8'h03;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            applyStimulus(ck, gapMode);
`endif
        end
    endtask

    task automatic waitEnd(input string name);
        int n;
        n = 0;
        while (!(done || error) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(done || error)) timeoutFail(name, n);
        @(negedge clk); #1;
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    initial begin
        int len;
        logic [31:0] w3[3];

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset inReady",   32'(inReady),   32'd0);
        checkOutput("reset imemWe",    32'(imemWe),    32'd0);
        checkOutput("reset cpuReset",  32'(cpuReset),  32'd1);
        checkOutput("reset done",      32'(done),      32'd0);
        checkOutput("reset wordCount", 32'(wordCount), 32'd0);
        resetN = 1'b1;
        @(posedge clk); #1;
        checkOutput("inReady after reset", 32'(inReady), 32'd1);
        pulseReload();   // ignored outside DONE/ERROR
        checkOutput("reload ignored in SYNC", 32'(inReady), 32'd1);

        // Two-word frame from the test plan.
        txGarbage.delete(); txData.delete();
        pushWord(32'h00000013); pushWord(32'h00100093);
        sendFrame(2, 0, 1'b1);
        waitEnd("frame1");
        checkOutput("f1 writes", 32'(capData.size()), 32'd2);
        checkOutput("f1 addr0", 32'(capAddr[0]), 32'd0);
        checkOutput("f1 data0", capData[0], 32'h00000013);
        checkOutput("f1 addr1", 32'(capAddr[1]), 32'd1);
        checkOutput("f1 data1", capData[1], 32'h00100093);
        checkOutput("f1 done", 32'(done), 32'd1);
        checkOutput("f1 cpuReset", 32'(cpuReset), 32'd0);
        checkOutput("f1 wordCount", 32'(wordCount), 32'd2);
        pulseReload();
        checkOutput("reload cpuReset", 32'(cpuReset), 32'd1);
        checkOutput("reload wordCount", 32'(wordCount), 32'd0);

        // Leading garbage is skipped.
        txGarbage = '{8'h00, 8'hFF, 8'h5A};
        txData.delete();
        pushWord(32'hDEADBEEF);
        sendFrame(1, 0, 1'b1);
        waitEnd("garbage");
        checkOutput("garbage writes", 32'(capData.size()), 32'd1);
        checkOutput("garbage data", capData[0], 32'hDEADBEEF);
        checkOutput("garbage addr", 32'(capAddr[0]), 32'd0);
        pulseReload();
        txGarbage.delete();

        // Oversize length is rejected right after LEN_HI.
        txData.delete();
        sendFrame(65, 0, 1'b1);
        waitEnd("oversize");
        checkOutput("oversize error", 32'(error), 32'd1);
        checkOutput("oversize cpuReset", 32'(cpuReset), 32'd1);
        checkOutput("oversize writes", 32'(capData.size()), 32'd0);
        pulseReload();
        checkOutput("reload clears error", 32'(error), 32'd0);
        checkOutput("reload ready", 32'(inReady), 32'd1);

        // Three words gap-free, then with inValid toggling.
        w3 = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
        for (int pass = 0; pass < 2; pass++) begin
            txData.delete();
            for (int i = 0; i < 3; i++) pushWord(w3[i]);
            sendFrame(3, pass, 1'b1);
            waitEnd("three-word");
            checkOutput("3w pulse cycles", 32'(weCycles), 32'd3);
            for (int i = 0; i < 3; i++) begin
                checkOutput("3w data", capData[i], w3[i]);
                checkOutput("3w addr", 32'(capAddr[i]), 32'(i));
            end
            pulseReload();
        end

        // Reset mid-frame after two data bytes, then a clean reload.
        applyStimulus(8'hA5, 0); applyStimulus(8'h01, 0); applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0); applyStimulus(8'hBB, 0);
        #2 resetN = 1'b0;
        #1;
        checkOutput("abort inReady",   32'(inReady),   32'd0);
        checkOutput("abort imemAddr",  32'(imemAddr),  32'd0);
        checkOutput("abort imemData",  imemData,       32'd0);
        checkOutput("abort cpuReset",  32'(cpuReset),  32'd1);
        checkOutput("abort error",     32'(error),     32'd0);
        checkOutput("abort wordCount", 32'(wordCount), 32'd0);
        @(posedge clk); #1;
        resetN = 1'b1;
        @(posedge clk); #1;
        txData.delete();
        pushWord(32'hCAFEF00D);
        sendFrame(1, 0, 1'b1);
        waitEnd("after abort");
        checkOutput("after abort data", capData[0], 32'hCAFEF00D);
        checkOutput("after abort done", 32'(done), 32'd1);
        pulseReload();

        // LEN = 0 completes with no writes.
        txData.delete();
        sendFrame(0, 0, 1'b1);
        waitEnd("len0");
        checkOutput("len0 done", 32'(done), 32'd1);
        checkOutput("len0 writes", 32'(capData.size()), 32'd0);
        pulseReload();

        // LEN = DEPTH fills the whole memory.
        txData.delete();
        for (int i = 0; i < DEPTH; i++) pushWord($urandom);
        sendFrame(DEPTH, 0, 1'b1);
        waitEnd("full");
        checkOutput("full writes", 32'(capData.size()), 32'(DEPTH));
        checkOutput("full last addr", 32'(capAddr[DEPTH-1]), 32'(DEPTH-1));
        checkOutput("full wordCount", 32'(wordCount), 32'(DEPTH));
        pulseReload();

        // Length rejected through its high byte.
        txData.delete();
        sendFrame(256, 0, 1'b1);
        waitEnd("len256");
        checkOutput("len256 error", 32'(error), 32'd1);
        pulseReload();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Trailing checksum byte: 05 matches, 06 does not.
        txData.delete();
        pushWord(32'h04030201);
        sendFrame(1, 0, 1'b1);
        waitEnd("ck good");
        checkOutput("ck good done", 32'(done), 32'd1);
        pulseReload();
        sendFrame(1, 0, 1'b0);
        waitEnd("ck bad");
        checkOutput("ck bad error", 32'(error), 32'd1);
        checkOutput("ck bad cpuReset", 32'(cpuReset), 32'd1);
        checkOutput("ck bad data", capData[0], 32'h04030201);
        pulseReload();
`endif

        // Randomized frames with garbage, gaps and occasional bad lengths.
        for (int f = 0; f < 10; f++) begin
            txGarbage.delete();
            txData.delete();
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h00;
                txGarbage.push_back(gb);
            end
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH + 1, 300)
                                              : $urandom_range(0, DEPTH);
            if (len <= DEPTH) for (int i = 0; i < len; i++) pushWord($urandom);
            sendFrame(len, 2, $urandom_range(0, 3) != 0);
            waitEnd("random frame");
            checkOutput("random status", 32'({done, error}), 32'({mDone, mErr}));
            pulseReload();
        end
        txGarbage.delete();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
